// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit scan driver with shadow/active double buffering for a shared 3-bit decoder.
// Optional inter-digit blanking gap is compiled in with `define DISPLAY_BLANK_EN.
module display_scan_controller #(
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [11:0] load_data,
  output logic [2:0]  code_out,
  output logic [3:0]  digit_en,
  output logic        load_ack,
  output logic        frame_start
);

  localparam int PW = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV_MAX);
  localparam logic [7:0]    BLK_LAST = 8'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [PW-1:0] pre, pre_n;
  logic [7:0]    blk, blk_n;
  logic [11:0]   shadow, shadow_n;
  logic [11:0]   active, active_n;
  logic          pending, pending_n;
  logic [2:0]    code_n;
  logic [3:0]    digit_en_n;
  logic          load_ack_n, frame_start_n;
  logic          enter0;

  function automatic logic [2:0] digit_code(input logic [11:0] a, input logic [1:0] i);
    case (i)
      2'd0:    digit_code = a[2:0];
      2'd1:    digit_code = a[5:3];
      2'd2:    digit_code = a[8:6];
      default: digit_code = a[11:9];
    endcase
  endfunction

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pre_n   = pre;
    blk_n   = blk;
    enter0  = 1'b0;
    case (state)
      IDLE: begin
        idx_n = 2'd0;
        pre_n = '0;
        blk_n = 8'd0;
        if (enable) begin
          state_n = SHOW;
          enter0  = 1'b1;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = 2'd0;
          pre_n   = '0;
          blk_n   = 8'd0;
        end else if (pre == PRE_LAST) begin
          pre_n = '0;
`ifdef DISPLAY_BLANK_EN
          state_n = BLANK;
          blk_n   = 8'd0;
`else
          idx_n  = idx + 2'd1;
          enter0 = (idx == 2'd3);
`endif
        end else begin
          pre_n = pre + 1'b1;
        end
      end
      BLANK: begin
        // Unreachable unless SHOW exits here, i.e. only with the blanking gap built in.
        if (!enable) begin
          state_n = IDLE;
          idx_n   = 2'd0;
          pre_n   = '0;
          blk_n   = 8'd0;
        end else if (blk == BLK_LAST) begin
          state_n = SHOW;
          idx_n   = idx + 2'd1;
          blk_n   = 8'd0;
          enter0  = (idx == 2'd3);
        end else begin
          blk_n = blk + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A load coinciding with a frame commit goes straight to active.
  always_comb begin
    shadow_n      = load ? load_data : shadow;
    active_n      = active;
    pending_n     = pending | load;
    load_ack_n    = 1'b0;
    frame_start_n = enter0;
    if (enter0 && (pending || load)) begin
      active_n   = load ? load_data : shadow;
      pending_n  = 1'b0;
      load_ack_n = 1'b1;
    end
    digit_en_n = (state_n == SHOW) ? (4'b0001 << idx_n) : 4'b0000;
    case (state_n)
      SHOW:    code_n = digit_code(active_n, idx_n);
      BLANK:   code_n = code_out;
      default: code_n = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 2'd0;
      pre         <= '0;
      blk         <= 8'd0;
      shadow      <= 12'd0;
      active      <= 12'd0;
      pending     <= 1'b0;
      code_out    <= 3'b000;
      digit_en    <= 4'b0000;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      pre         <= pre_n;
      blk         <= blk_n;
      shadow      <= shadow_n;
      active      <= active_n;
      pending     <= pending_n;
      code_out    <= code_n;
      digit_en    <= digit_en_n;
      load_ack    <= load_ack_n;
      frame_start <= frame_start_n;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: a frame-position model pushes expected outputs each edge.
module tb_display_scan_controller;

  localparam int DIV_MAX = 3;
  localparam int BLANK_CYCLES = 2;
`ifdef DISPLAY_BLANK_EN
  localparam int GAP = BLANK_CYCLES;
`else
  localparam int GAP = 0;
`endif
  localparam int PER   = DIV_MAX + 1 + GAP;
  localparam int FRAME = 4 * PER;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_data = 12'd0;
  logic [2:0]  code_out;
  logic [3:0]  digit_en;
  logic        load_ack;
  logic        frame_start;

  display_scan_controller #(.DIV_MAX(DIV_MAX), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_data(load_data),
    .code_out(code_out), .digit_en(digit_en), .load_ack(load_ack), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] den;
    logic [2:0] code;
    logic       fs;
    logic       ack;
  } exp_t;

  exp_t        sbq[$];
  exp_t        m_last;
  int          total = 0;
  int          bad = 0;
  bit          m_run = 0;
  int          m_t = 0;
  logic [11:0] m_sh = 0, m_act = 0;
  bit          m_pend = 0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    bit   comm = 0;
    int   p, d;
    e = m_last;
    e.fs = 1'b0;
    e.ack = 1'b0;
    if (reset) begin
      m_run = 0; m_t = 0; m_sh = 0; m_act = 0; m_pend = 0;
      e.den = 4'd0; e.code = 3'd0;
    end else begin
      if (!enable) begin
        m_run = 0;
        e.den = 4'd0;
        e.code = 3'd0;
      end else begin
        if (!m_run) begin m_run = 1; m_t = 0; end
        else m_t = (m_t + 1) % FRAME;
        if (m_t == 0) begin
          e.fs = 1'b1;
          if (m_pend || load) begin
            m_act = load ? load_data : m_sh;
            m_pend = 0;
            e.ack = 1'b1;
            comm = 1;
          end
        end
        p = m_t % PER;
        d = m_t / PER;
        if (p <= DIV_MAX) begin
          e.den = 4'(1 << d);
          e.code = 3'(m_act >> (3 * d));
        end else begin
          e.den = 4'd0;
        end
      end
      if (load) begin
        m_sh = load_data;
        if (!comm) m_pend = 1;
      end
    end
    m_last = e;
    sbq.push_back(e);
  endtask

  task automatic step(input logic en_i, input logic ld_i, input logic [11:0] d_i);
    exp_t e;
    enable = en_i;
    load = ld_i;
    load_data = d_i;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = sbq.pop_front();
    chk("digit_en", 12'(digit_en), 12'(e.den));
    chk("code_out", 12'(code_out), 12'(e.code));
    chk("frame_start", 12'(frame_start), 12'(e.fs));
    chk("load_ack", 12'(load_ack), 12'(e.ack));
    chk("onehot0", 12'($onehot0(digit_en)), 12'd1);
    load = 1'b0;
  endtask

  task automatic run_until_digit(input int dg, input int ph);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_run && (m_t / PER) == dg && (m_t % PER) == ph) break;
      step(1'b1, 1'b0, 12'd0);
    end
    chk("reached_digit", 12'(m_t / PER), 12'(dg));
  endtask

  initial begin
    m_last.den = 0; m_last.code = 0; m_last.fs = 0; m_last.ack = 0;
    #1;
    chk("rst_digit_en", 12'(digit_en), 12'd0);
    chk("rst_code_out", 12'(code_out), 12'd0);
    chk("rst_load_ack", 12'(load_ack), 12'd0);
    chk("rst_frame_start", 12'(frame_start), 12'd0);
    step(1'b1, 1'b0, 12'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, 12'd0);
    step(1'b0, 1'b1, 12'o7531);
    for (int i = 0; i < 2 * FRAME + 3; i++) step(1'b1, 1'b0, 12'd0);

    run_until_digit(2, 1);
    step(1'b1, 1'b1, 12'o1111);
    run_until_digit(3, 0);
    step(1'b1, 1'b1, 12'o2222);
    for (int i = 0; i < FRAME + 4; i++) step(1'b1, 1'b0, 12'd0);

    run_until_digit(1, 1);
    step(1'b0, 1'b0, 12'd0);
    chk("drop_dark", 12'(digit_en), 12'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'd0);
    for (int i = 0; i < FRAME + 2; i++) step(1'b1, 1'b0, 12'd0);

    // Same-cycle load and commit.
    run_until_digit(3, PER - 1);
    step(1'b1, 1'b1, 12'o3456);
    for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 12'd0);

    run_until_digit(1, 1);
    step(1'b1, 1'b1, 12'o4444);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_digit_en", 12'(digit_en), 12'd0);
    chk("async_rst_code_out", 12'(code_out), 12'd0);
    step(1'b1, 1'b0, 12'd0);
    reset = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) step(1'b1, 1'b0, 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter DIV_MAX, default 49999, SHALL set the number of clk cycles each digit is shown minus one (counter range 0..DIV_MAX).
REQ-002 Parameter BLANK_CYCLES, default 4, range 1..255, SHALL set the length of the inter-digit blanking gap when DISPLAY_BLANK_EN is defined.
REQ-003 Port clk, input, 1: single system clock; all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port enable, input, 1: 1 = scan running, 0 = display dark.
REQ-006 Port load, input, 1: single-cycle request to capture load_data.
REQ-007 Port load_data, input, 12: four 3-bit digit codes; bits [2:0] = digit 0 ... [11:9] = digit 3.
REQ-008 Port code_out, output, 3: code for the shared 3-bit 7-segment decoder; bit 2 drives decoder input A, bit 1 drives B, bit 0 drives C.
REQ-009 Port digit_en, output, 4: one-hot active-high digit select; bit n lights digit n.
REQ-010 Port load_ack, output, 1: one-cycle pulse when shadow data is committed to the displayed set.
REQ-011 Port frame_start, output, 1: one-cycle pulse when digit 0 begins a SHOW period.

Function
REQ-012 The block SHALL hold a 12-bit shadow register, a 12-bit active register, a pending flag, a 2-bit digit index, a prescale counter wide enough for DIV_MAX, and an 8-bit blank counter.
REQ-013 The FSM SHALL have states IDLE, SHOW, BLANK; all outputs SHALL be registered.
REQ-014 load=1 SHALL write load_data into shadow and set pending on the same edge, in any state; a load while pending is set SHALL overwrite shadow, keep pending=1, and produce no extra ack.
REQ-015 IDLE: digit_en=0000, code_out=000, index=0, prescale=0; when enable=1, the next state SHALL be SHOW with index 0.
REQ-016 On every entry to SHOW with index 0, if pending=1 the active register SHALL be loaded from shadow, pending cleared, and load_ack pulsed for that cycle; frame_start SHALL pulse on that same cycle.
REQ-017 A load arriving on the same cycle as a commit SHALL be committed (the new load_data is used) and load_ack SHALL pulse.
REQ-018 SHOW: digit_en = one-hot(index), code_out = active[3*index+2 : 3*index]; prescale increments each cycle; at prescale=DIV_MAX it SHALL reset to 0 and leave SHOW, so each digit is lit exactly DIV_MAX+1 cycles.
REQ-019 Leaving SHOW SHALL go to BLANK (macro defined) or directly to SHOW with index+1 (macro undefined); index SHALL wrap 3 -> 0.
REQ-020 BLANK: digit_en=0000, code_out holds; after exactly BLANK_CYCLES cycles the next state SHALL be SHOW with index+1 (wrapping).
REQ-021 enable=0 in SHOW or BLANK SHALL force IDLE on the next edge, clearing index and counters; shadow, active and pending SHALL be kept.
REQ-022 digit_en SHALL never have more than one bit set on any cycle.

Reset
REQ-023 reset=1 SHALL asynchronously force IDLE, digit_en=0000, code_out=000, load_ack=0, frame_start=0, index=0, prescale=0, blank counter=0, shadow=0, active=0, pending=0.
REQ-024 Reset asserted mid-SHOW or mid-BLANK SHALL blank the display immediately without waiting for a clock edge; a pending load SHALL be discarded.
REQ-025 After reset release the block SHALL start in IDLE, with the first SHOW no earlier than the first edge with enable=1.

Configuration
REQ-026 Macro DISPLAY_BLANK_EN SHALL, when defined, compile in the BLANK state and blank counter (anti-ghosting gap between digits); when undefined, BLANK, its counter and BLANK_CYCLES SHALL have no effect and digits SHALL switch back-to-back, giving a frame period of 4*(DIV_MAX+1) cycles instead of 4*(DIV_MAX+1+BLANK_CYCLES).

Verification (DIV_MAX=3, BLANK_CYCLES=2)
REQ-027 Reset, load_data=12'o7531 pulse, enable=1 -> frame_start and load_ack pulse together; digit_en 0001 with code 001 for 4 cycles, then 0000 for 2, then 0010 with 011, 0100 with 101, 1000 with 111; wrap to 0001.
REQ-028 Macro undefined, same stimulus -> no 0000 gaps; frame_start every 16 cycles.
REQ-029 Load 12'o1111 during digit 2, then 12'o2222 during digit 3 -> single load_ack at next digit-0 entry; code_out shows 010 on all digits.
REQ-030 enable dropped mid-digit 1 -> digit_en=0000 next cycle; re-enable -> restart at digit 0 with the previous codes.
REQ-031 reset pulsed between edges mid-SHOW -> digit_en=0000 and code_out=000 before the next edge; a pending load produces no ack afterwards.
REQ-032 All runs -> assertion that digit_en is always one-hot or zero.
